lcd_tx_queue: RTL and testbench
===============================

// Module: lcd_tx_queue
// PURPOSE
//  Upstream feeder for the LCD SPI byte engine. Buffers 9-bit LCD entries {CMDn/DATA, byte}
//  written by the bus-side logic in a FIFO and drains them one at a time into the SPI engine
//  through a start/busy handshake. Inserts a programmable inter-byte gap.
//  Raises a drain-complete interrupt so software can queue whole page updates without polling.
// PARAMETERS
//  DEPTH_LOG2   4    FIFO depth = 2**DEPTH_LOG2 entries (16)
//  GAP_CYCLES   2    idle i_sysclk cycles between busy falling and next o_tx_start (>=1)
//  ACK_TIMEOUT  64   cycles to wait for i_tx_busy rise after o_tx_start before declaring error
// PORTS
//  i_sysclk     in   1             system clock; all logic on rising edge
//  i_sysrst     in   1             synchronous, active-high reset
//  i_wr_en      in   1             push i_wr_data this cycle
//  i_wr_data    in   9             [8]=CMDn/DATA (0=cmd,1=data), [7:0]=byte
//  i_flush      in   1             discard all queued entries
//  i_irq_clr    in   1             clear o_irq and o_err
//  o_full       out  1             FIFO full
//  o_empty      out  1             FIFO empty
//  o_level      out  DEPTH_LOG2+1  entries queued (0..DEPTH)
//  o_overflow   out  1             sticky: push attempted while full; cleared by i_flush
//  o_tx_start   out  1             one-cycle start pulse to SPI engine
//  o_tx_dc      out  1             CMDn/DATA for current byte, stable from start until busy falls
//  o_tx_byte    out  8             byte for SPI engine, stable as o_tx_dc
//  i_tx_busy    in   1             SPI engine busy flag
//  o_irq        out  1             sticky: queue drained (last byte done, FIFO empty)
//  o_err        out  1             sticky: handshake timeout
// BEHAVIOUR
//  Reset: FIFO empty, o_level=0, o_full=0, o_empty=1, all other outputs 0, FSM IDLE, counters 0.
//  Reset mid-transfer abandons the byte; no wait for i_tx_busy.
//  FIFO: synchronous, registered pointers, wrap modulo DEPTH. Push when full is dropped and
//  sets o_overflow; this holds even if a pop happens the same cycle. Push+pop when neither
//  full nor empty: both happen, level unchanged. Push into empty FIFO visible next cycle.
//  FSM (registered outputs):
//   IDLE:  if !o_empty -> pop head into o_tx_dc/o_tx_byte, assert o_tx_start, go ACK.
//   ACK:   o_tx_start low. i_tx_busy=1 -> BUSY. Timeout after ACK_TIMEOUT cycles
//          -> set o_err, drop byte, go GAP.
//   BUSY:  wait i_tx_busy=0 -> GAP.
//   GAP:   count GAP_CYCLES, then -> IDLE. On exit, if FIFO empty set o_irq.
//  Latency: push into empty idle queue at cycle N -> o_tx_start high at N+2.
//  Throughput: one byte per (SPI busy time + GAP_CYCLES + 2) cycles.
//  o_irq/o_err: set wins over simultaneous i_irq_clr. o_irq set only once per drain.
//  i_flush: clears pointers/level and o_overflow next cycle. In-flight byte (ACK/BUSY/GAP)
//  completes normally. Push in the same cycle as flush is discarded. Flush from IDLE never
//  sets o_irq.
//  o_tx_dc/o_tx_byte hold the last value while IDLE.
// STRUCTURE
//  lcd_defs.vh (shared include): FSM state encodings (IDLE/ACK/BUSY/GAP), entry width 9,
//  DC bit index 8, CMD=0/DATA=1 constants; also used by the SPI engine register map.
//  One sub-module: lcd_sync_fifo (width 9, DEPTH_LOG2; push/pop/flush, full/empty/level).
//  Top: FSM, gap/timeout counter, sticky flags.
// TESTING
//  1. Push {0,0xAF} into idle queue at cycle N, bench busy model (rise +1, 20-cycle busy)
//     -> o_tx_start at N+2, dc=0, byte=0xAF; o_irq=1 at end of GAP.
//  2. Push 16 entries 0x100..0x10F back-to-back, busy stalled
//     -> o_full after 16th; 17th push sets o_overflow.
//     Bytes 0x00..0x0F emerge in order, all dc=1.
//  3. Full FIFO plus push and pop in the same cycle -> push dropped, o_overflow=1, level 15.
//  4. Hold i_tx_busy=0 after start, ACK_TIMEOUT=64 -> o_err=1 at start+65, next entry issued
//     after GAP; i_irq_clr -> o_err=0.
//  5. Queue 5 entries, assert i_flush during BUSY of entry 1
//     -> entry 1 completes, level=0 next cycle, no further o_tx_start, o_irq=1 after GAP.
//  6. Assert i_sysrst during BUSY with 3 queued
//     -> next cycle all outputs 0, o_empty=1, level 0; no o_tx_start after release.

Source files
------------

// File: rtl/lcd_tx_queue_pkg.sv
// Shared LCD queue definitions: entry layout, FSM states, entry unpack helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lcd_tx_queue_pkg;

    // One queued LCD entry is {CMDn/DATA, byte}.
    localparam int ENTRY_W = 9;
    localparam int DC_BIT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_BUSY = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic       dc;
        logic [7:0] dat;
    } lcd_entry_t;

    // Split a raw FIFO word into its DC flag and payload byte.
    function automatic lcd_entry_t to_entry(logic [ENTRY_W-1:0] raw);
        lcd_entry_t e;
        e.dc  = raw[DC_BIT];
        e.dat = raw[7:0];
        return e;
    endfunction

endpackage

// File: rtl/lcd_tx_queue_fifo.sv
// Synchronous FIFO with registered pointers, level count, flush and sticky overflow.
// Latency: a push is visible on empty/level/head the cycle after it is written.
// Backpressure: pushes while full are dropped and flagged; a pop in the same cycle does not make room.
module lcd_tx_queue_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  full, empty;
    logic                  push_ok, pop_ok;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    // Fullness is judged on the registered level, so a same-cycle pop never admits a push.
    assign push_ok = push_i && !full  && !flush_i;
    assign pop_ok  = pop_i  && !empty && !flush_i;

    // Next-state for pointers, level and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_i && full) begin
                ovf_d = 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = full;
    assign empty_o    = empty;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/lcd_tx_queue.sv
// LCD entry queue feeding the SPI byte engine via start/busy, with inter-byte gap and drain irq.
// Latency: push into an empty idle queue at cycle N gives o_tx_start at N+2.
// Backpressure: engine stalls via i_tx_busy; queue overflow drops the push and sets o_overflow.
module lcd_tx_queue
    import lcd_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  i_sysclk,
    input  logic                  i_sysrst,
    input  logic                  i_wr_en,
    input  logic [8:0]            i_wr_data,
    input  logic                  i_flush,
    input  logic                  i_irq_clr,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_tx_start,
    output logic                  o_tx_dc,
    output logic [7:0]            o_tx_byte,
    input  logic                  i_tx_busy,
    output logic                  o_irq,
    output logic                  o_err
);

    // One counter serves both the ack timeout and the gap, so size it for the larger.
    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACK_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               dc_q, dc_d;
    logic [7:0]         byte_q, byte_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;
    logic               irq_set, err_set;

    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    lcd_entry_t         head;

    lcd_tx_queue_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i       (i_sysclk),
        .rst_i       (i_sysrst),
        .push_i      (i_wr_en),
        .push_data_i (i_wr_data),
        .pop_i       (fifo_pop),
        .flush_i     (i_flush),
        .head_o      (fifo_head),
        .full_o      (o_full),
        .empty_o     (fifo_empty),
        .level_o     (o_level),
        .overflow_o  (o_overflow)
    );

    assign head = to_entry(fifo_head);

    // Drain FSM: issue head, wait for engine ack, wait for engine done, then hold off for the gap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        dc_d     = dc_q;
        byte_d   = byte_q;
        fifo_pop = 1'b0;
        irq_set  = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A flush this cycle discards the head too, so nothing is issued.
                if (!fifo_empty && !i_flush) begin
                    fifo_pop = 1'b1;
                    dc_d     = head.dc;
                    byte_d   = head.dat;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (i_tx_busy) begin
                    state_d = ST_BUSY;
                end else if (cnt_q == ACK_LIMIT) begin
                    // Engine never acknowledged: give up on this byte and move on.
                    err_set = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!i_tx_busy) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    irq_set = fifo_empty;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        irq_d = irq_set | (irq_q & ~i_irq_clr);
        err_d = err_set | (err_q & ~i_irq_clr);
    end

    // State, counter and registered engine-facing outputs.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            dc_q    <= 1'b0;
            byte_q  <= 8'h00;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            dc_q    <= dc_d;
            byte_q  <= byte_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    assign o_empty    = fifo_empty;
    assign o_tx_start = start_q;
    assign o_tx_dc    = dc_q;
    assign o_tx_byte  = byte_q;
    assign o_irq      = irq_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_lcd_tx_queue.sv
// Bench for lcd_tx_queue: queue-based reference model compared every cycle, plus directed literal checks.
// Latency: n/a.
// Backpressure: an SPI busy model answers o_tx_start, or the stimulus drives busy by hand.
module tb_lcd_tx_queue;

    localparam int GAP    = 2;
    localparam int ACK_TO = 64;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst, wr_en, flush, irq_clr, tx_busy;
    logic [8:0] wr_data;
    logic       full, empty, ovf, tx_start, tx_dc, irq, err;
    logic [4:0] level;
    logic [7:0] tx_byte;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    lcd_tx_queue dut (
        .i_sysclk   (clk),
        .i_sysrst   (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_flush    (flush),
        .i_irq_clr  (irq_clr),
        .o_full     (full),
        .o_empty    (empty),
        .o_level    (level),
        .o_overflow (ovf),
        .o_tx_start (tx_start),
        .o_tx_dc    (tx_dc),
        .o_tx_byte  (tx_byte),
        .i_tx_busy  (tx_busy),
        .o_irq      (irq),
        .o_err      (err)
    );

    // ---------------- reference model: a queue plus transfer timestamps ----------------
    logic [8:0] mq[$];
    int   sz, t_start, gap_end;
    bit   inflight, seen_busy, do_pop, set_irq, set_err;
    logic m_ovf = 0, m_irq = 0, m_err = 0, m_start = 0, m_dc = 0;
    logic [7:0] m_byte = 0;

    always @(posedge clk) begin
        sz = mq.size();
        m_start = 1'b0;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_irq = 0; m_err = 0; m_dc = 0; m_byte = 0;
            inflight = 0; seen_busy = 0; gap_end = -1;
        end else begin
            do_pop = 0; set_irq = 0; set_err = 0;
            if (inflight) begin
                if (gap_end >= 0) begin
                    if (cyc == gap_end) begin
                        inflight = 0;
                        if (sz == 0) set_irq = 1;
                    end
                end else if (!seen_busy) begin
                    if (tx_busy) seen_busy = 1;
                    else if (cyc == t_start + ACK_TO) begin
                        set_err = 1;
                        gap_end = cyc + GAP;
                    end
                end else if (!tx_busy) begin
                    gap_end = cyc + GAP;
                end
            end else if (sz > 0 && !flush) begin
                do_pop = 1;
                {m_dc, m_byte} = mq[0];
                m_start = 1'b1;
                inflight = 1; seen_busy = 0; gap_end = -1;
                t_start = cyc + 1;
            end
            if (flush) begin
                mq.delete();
                m_ovf = 0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (wr_en) begin
                    if (sz == DEPTH) m_ovf = 1;
                    else mq.push_back(wr_data);
                end
            end
            if (irq_clr) begin m_irq = 0; m_err = 0; end
            if (set_irq) m_irq = 1;
            if (set_err) m_err = 1;
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    logic [19:0] act_v, exp_v;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = {(mq.size() == DEPTH), (mq.size() == 0), 5'(mq.size()), m_ovf,
                     m_start, m_dc, m_byte, m_irq, m_err};
            act_v = {full, empty, level, ovf, tx_start, tx_dc, tx_byte, irq, err};
            vectors++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp cycle %0d: got %h expected %h", cyc, act_v, exp_v);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit busy_auto = 0, rise_next = 0;
    int busy_left = 0, busy_len = 20;

    // Advance to the next falling edge, then run the SPI busy model if enabled.
    task automatic tick();
        @(negedge clk);
        if (busy_auto) begin
            if (rise_next) begin
                tx_busy = 1'b1; rise_next = 0; busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            if (tx_start === 1'b1) rise_next = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [8:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_auto(input int len);
        busy_auto = 1; busy_len = len; rise_next = 0; busy_left = 0;
    endtask

    // which: 0 = o_tx_start, 1 = o_irq, 2 = o_err
    task automatic wait_for(input int which, input int limit, input string name, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if ((which == 0 && tx_start === 1'b1) || (which == 1 && irq === 1'b1) ||
                (which == 2 && err === 1'b1)) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            vectors++; errors++;
            $display("FAIL %s: event not seen within %0d cycles (got none, required one)", name, limit);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 0; flush = 0; irq_clr = 0; tx_busy = 0;
        busy_auto = 0; rise_next = 0; busy_left = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    int n, s, t, starts;

    initial begin
        wr_data = '0;
        do_reset();
        chk_en = 1;
        check("reset_empty", empty, 1);
        check("reset_level", level, 0);
        check("reset_start", tx_start, 0);

        // 1: single command byte through idle queue, 20-cycle busy
        set_auto(20);
        n = cyc;
        push(9'h0AF);
        wait_for(0, 10, "t1_start", t);
        check("t1_start_cycle", t, n + 2);
        check("t1_dc", tx_dc, 0);
        check("t1_byte", tx_byte, 8'hAF);
        wait_for(1, 60, "t1_irq", t);
        check("t1_irq_cycle", t, n + 26);

        // 2: fill 16 behind a stalled engine, overflow on 17th, drain in order
        do_reset();
        push(9'h1EE);
        wait_for(0, 10, "t2_dummy_start", s);
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(9'h100 + 9'(i));
        check("t2_full", full, 1);
        check("t2_level16", level, 16);
        check("t2_no_ovf_yet", ovf, 0);
        push(9'h1FF);
        check("t2_overflow", ovf, 1);
        check("t2_level_kept", level, 16);
        tx_busy = 1'b0;
        set_auto(3);
        for (int k = 0; k < 16; k++) begin
            wait_for(0, 40, "t2_drain_start", t);
            check("t2_drain_byte", tx_byte, k);
            check("t2_drain_dc", tx_dc, 1);
            tick();
        end
        wait_for(1, 40, "t2_irq", t);

        // 3: push into a full FIFO in the same cycle the FSM pops
        do_reset();
        push(9'h1EE);
        wait_for(0, 10, "t3_dummy_start", s);
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(9'h100 + 9'(i));
        check("t3_full", full, 1);
        tx_busy = 1'b0;
        tick(); tick(); tick();
        set_auto(3);
        push(9'h1AA);
        check("t3_popped", tx_start, 1);
        check("t3_head_byte", tx_byte, 8'h00);
        check("t3_level15", level, 15);
        check("t3_overflow", ovf, 1);

        // 4: ack timeout, next entry after gap, irq_clr clears err
        do_reset();
        push(9'h055);
        push(9'h1C3);
        wait_for(0, 10, "t4_start", s);
        wait_for(2, 80, "t4_err", t);
        check("t4_err_cycle", t, s + 65);
        set_auto(5);
        wait_for(0, 10, "t4_next_start", t);
        check("t4_next_cycle", t, s + 68);
        check("t4_next_byte", tx_byte, 8'hC3);
        check("t4_next_dc", tx_dc, 1);
        wait_for(1, 40, "t4_irq", t);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t4_err_cleared", err, 0);
        check("t4_irq_cleared", irq, 0);

        // 5: flush during BUSY of entry 1 (with a discarded push in the flush cycle)
        do_reset();
        set_auto(20);
        n = cyc;
        for (int i = 0; i < 5; i++) push(9'h010 + 9'(i));
        tick(); tick();
        flush = 1'b1; wr_en = 1'b1; wr_data = 9'h1FF;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("t5_level0", level, 0);
        check("t5_empty", empty, 1);
        wait_for(1, 40, "t5_irq", t);
        check("t5_irq_cycle", t, n + 26);
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        check("t5_no_more_starts", starts, 0);

        // 6: reset while BUSY with 3 entries queued
        do_reset();
        set_auto(20);
        for (int i = 0; i < 4; i++) push(9'h020 + 9'(i));
        tick();
        rst = 1'b1;
        tick();
        check("t6_empty", empty, 1);
        check("t6_level", level, 0);
        check("t6_outputs", {full, ovf, tx_start, tx_dc, tx_byte, irq, err}, 0);
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        check("t6_no_starts", starts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
